// File: rtl/alu_pkg.sv
// alu_pkg: shared constants for the multi-cycle Jac1-8 ALU
// Holds opcode encodings, status bit indices, FSM state encoding and default widths.
package alu_pkg;
    localparam int DATA_WIDTH      = 8;
    localparam int NUM_STATUS_BITS = 2;
    localparam int STAT_CARRY      = 0;
    localparam int STAT_ZERO       = 1;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_ADC  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_SBC  = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_OR   = 4'd5;
    localparam logic [3:0] OP_XOR  = 4'd6;
    localparam logic [3:0] OP_NOT  = 4'd7;
    localparam logic [3:0] OP_SHL  = 4'd8;
    localparam logic [3:0] OP_SHR  = 4'd9;
    localparam logic [3:0] OP_ROL  = 4'd10;
    localparam logic [3:0] OP_ROR  = 4'd11;
    localparam logic [3:0] OP_MUL  = 4'd12;
    localparam logic [3:0] OP_MULH = 4'd13;
    localparam logic [3:0] OP_CMP  = 4'd14;
    localparam logic [3:0] OP_PASS = 4'd15;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_MUL  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    function automatic logic is_mul(input logic [3:0] op);
        return op == OP_MUL || op == OP_MULH;
    endfunction
endpackage

// File: rtl/alu_mul_serial.sv
// alu_mul_serial: unsigned shift-add multiplier, one multiplier bit per clock
// Ports: clk, res_n (async active-low); load captures a/b and restarts;
// product is the running accumulator, valid once ready is high.
module alu_mul_serial
    import alu_pkg::*;
#(
    parameter int DataWidth = DATA_WIDTH
) (
    input  logic                     clk,
    input  logic                     res_n,
    input  logic                     load,
    input  logic [DataWidth-1:0]     a,
    input  logic [DataWidth-1:0]     b,
    output logic [2*DataWidth-1:0]   product,
    output logic                     ready
);
    localparam int CW = $clog2(DataWidth + 1);

    logic [2*DataWidth-1:0] mcand;
    logic [DataWidth-1:0]   mplier;
    logic [CW-1:0]          cnt;

    assign ready = cnt == '0;

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            product <= '0;
            mcand   <= '0;
            mplier  <= '0;
            cnt     <= '0;
        end else if (load) begin
            product <= '0;
            mcand   <= {{DataWidth{1'b0}}, a};
            mplier  <= b;
            cnt     <= CW'(DataWidth);
        end else if (!ready) begin
            product <= mplier[0] ? product + mcand : product;
            mcand   <= mcand << 1;
            mplier  <= mplier >> 1;
            cnt     <= cnt - 1'b1;
        end
    end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle 8-bit ALU with start/busy/done handshake
// Inputs: clk, res_n (async active-low), start/op/a/b/carry_in sampled in IDLE.
// Outputs: busy, done pulse, result + result_wr_en, alu_status {zero,carry} + stat_wr_en.
module alu_seq
    import alu_pkg::*;
#(
    parameter int DataWidth     = DATA_WIDTH,
    parameter int NumStatusBits = NUM_STATUS_BITS
) (
    input  logic                     clk,
    input  logic                     res_n,
    input  logic                     start,
    input  logic [3:0]               op,
    input  logic [DataWidth-1:0]     a,
    input  logic [DataWidth-1:0]     b,
    input  logic                     carry_in,
    output logic                     busy,
    output logic                     done,
    output logic [DataWidth-1:0]     result,
    output logic                     result_wr_en,
    output logic [NumStatusBits-1:0] alu_status,
    output logic                     stat_wr_en
);
    logic [1:0]                 state;
    logic [3:0]                 op_q;
    logic [DataWidth-1:0]       a_q, b_q;
    logic                       c_q;
    logic [2*DataWidth-1:0]     prod;
    logic                       mul_ready;
    logic                       accept;
    logic [DataWidth:0]         add_s, sub_s;
    logic [DataWidth-1:0]       res_v;
    logic                       carry_v;
    logic [NumStatusBits-1:0]   stat_v;

    // busy stays high through the done cycle, which is what blocks a start there
    assign accept = state == ST_IDLE && start && !busy;

    alu_mul_serial #(.DataWidth(DataWidth)) u_mul (
        .clk     (clk),
        .res_n   (res_n),
        .load    (accept && is_mul(op)),
        .a       (a),
        .b       (b),
        .product (prod),
        .ready   (mul_ready)
    );

    // the MSB of a (DataWidth+1)-bit difference is the borrow
    assign add_s = {1'b0, a_q} + {1'b0, b_q} + {{DataWidth{1'b0}}, op_q == OP_ADC && c_q};
    assign sub_s = {1'b0, a_q} - {1'b0, b_q} - {{DataWidth{1'b0}}, op_q == OP_SBC && c_q};

    always_comb begin
        res_v   = a_q;
        carry_v = 1'b0;
        case (op_q)
            OP_ADD, OP_ADC:         {carry_v, res_v} = add_s;
            OP_SUB, OP_SBC, OP_CMP: {carry_v, res_v} = sub_s;
            OP_AND:                 res_v = a_q & b_q;
            OP_OR:                  res_v = a_q | b_q;
            OP_XOR:                 res_v = a_q ^ b_q;
            OP_NOT:                 res_v = ~a_q;
            OP_SHL:                 {carry_v, res_v} = {a_q, 1'b0};
            OP_SHR:                 {res_v, carry_v} = {1'b0, a_q};
            OP_ROL:                 {carry_v, res_v} = {a_q, c_q};
            OP_ROR:                 {res_v, carry_v} = {c_q, a_q};
            OP_MUL:                 {carry_v, res_v} = {|prod[2*DataWidth-1:DataWidth], prod[DataWidth-1:0]};
            OP_MULH:                res_v = prod[2*DataWidth-1:DataWidth];
            default:                res_v = a_q;
        endcase
        stat_v             = '0;
        stat_v[STAT_CARRY] = carry_v;
        stat_v[STAT_ZERO]  = is_mul(op_q) ? prod == '0 : res_v == '0;
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state        <= ST_IDLE;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            c_q          <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            result       <= '0;
            result_wr_en <= 1'b0;
            alu_status   <= '0;
            stat_wr_en   <= 1'b0;
        end else begin
            done         <= 1'b0;
            result_wr_en <= 1'b0;
            stat_wr_en   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (done) busy <= 1'b0;
                    if (accept) begin
                        op_q  <= op;
                        a_q   <= a;
                        b_q   <= b;
                        c_q   <= carry_in;
                        busy  <= 1'b1;
                        state <= is_mul(op) ? ST_MUL : ST_EXEC;
                    end
                end
                ST_EXEC: state <= ST_DONE;
                ST_MUL:  state <= mul_ready ? ST_DONE : ST_MUL;
                default: begin
                    done         <= 1'b1;
                    result_wr_en <= op_q != OP_CMP;
                    stat_wr_en   <= op_q != OP_PASS;
                    if (op_q != OP_CMP) result <= res_v;
                    if (op_q != OP_PASS) alu_status <= stat_v;
                    state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: self-checking bench for alu_seq against an arithmetic reference model
module tb_alu_seq;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         res_n = 1'b0;
    logic         start = 1'b0;
    logic [3:0]   op = '0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         carry_in = 1'b0;
    logic         busy, done, result_wr_en, stat_wr_en;
    logic [W-1:0] result;
    logic [1:0]   alu_status;

    int checks = 0;
    int failures = 0;
    int exp_result = 0;
    int exp_status = 0;

    alu_seq dut (
        .clk          (clk),
        .res_n        (res_n),
        .start        (start),
        .op           (op),
        .a            (a),
        .b            (b),
        .carry_in     (carry_in),
        .busy         (busy),
        .done         (done),
        .result       (result),
        .result_wr_en (result_wr_en),
        .alu_status   (alu_status),
        .stat_wr_en   (stat_wr_en)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the opcode table; status = zero*2 + carry
    function automatic void model(input int o, input int x, input int y, input int c,
                                  output int r, output int st);
        int s, cy, z, p;
        cy = 0;
        p  = x * y;
        case (o)
            0:  begin s = x + y;     r = s % 256; cy = int'(s > 255); end
            1:  begin s = x + y + c; r = s % 256; cy = int'(s > 255); end
            2, 14: begin s = x - y;  r = (s + 256) % 256; cy = int'(s < 0); end
            3:  begin s = x - y - c; r = (s + 512) % 256; cy = int'(s < 0); end
            4:  r = x & y;
            5:  r = x | y;
            6:  r = x ^ y;
            7:  r = 255 - x;
            8:  begin r = (x * 2) % 256;     cy = int'(x >= 128); end
            9:  begin r = x / 2;             cy = x % 2; end
            10: begin r = (x * 2 + c) % 256; cy = int'(x >= 128); end
            11: begin r = x / 2 + c * 128;   cy = x % 2; end
            12: begin r = p % 256;           cy = int'(p > 255); end
            13: r = p / 256;
            default: r = x;
        endcase
        z  = (o == 12 || o == 13) ? int'(p == 0) : int'(r == 0);
        st = z * 2 + cy;
    endfunction

    task automatic do_op(input int t_op, input int t_a, input int t_b, input int t_c, input string tag);
        int r, st, k;
        model(t_op, t_a, t_b, t_c, r, st);
        @(negedge clk);
        start = 1'b1; op = 4'(t_op); a = 8'(t_a); b = 8'(t_b); carry_in = t_c[0];
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check({tag, ".busy"}, 32'(busy), 32'd1);
        k = 0;
        while (k < 40) begin
            @(posedge clk);
            #1;
            k++;
            if (done) break;
        end
        check({tag, ".latency"}, 32'(k), (t_op == 12 || t_op == 13) ? W + 2 : 2);
        if (t_op != 14) exp_result = r;
        if (t_op != 15) exp_status = st;
        check({tag, ".result"}, 32'(result), 32'(exp_result));
        check({tag, ".status"}, 32'(alu_status), 32'(exp_status));
        check({tag, ".res_we"}, 32'(result_wr_en), 32'(t_op != 14));
        check({tag, ".stat_we"}, 32'(stat_wr_en), 32'(t_op != 15));
        @(posedge clk);
        #1;
        check({tag, ".done_once"}, {29'd0, done, result_wr_en, stat_wr_en}, 32'd0);
        check({tag, ".idle"}, 32'(busy), 32'd0);
        check({tag, ".hold"}, {16'd0, result, 6'd0, alu_status}, 32'(exp_result * 256 + exp_status));
    endtask

    initial begin
        int r, st, dones, busy_low;
        #12;
        check("reset.outs", {27'd0, busy, done, result_wr_en, stat_wr_en, |alu_status}, 32'd0);
        check("reset.result", 32'(result), 32'd0);
        @(negedge clk);
        res_n = 1'b1;

        do_op(0, 'hF0, 'h20, 0, "add");
        do_op(2, 'h05, 'h05, 0, "sub");
        do_op(14, 'h03, 'h04, 0, "cmp");
        do_op(10, 'h80, 0, 1, "rol");
        do_op(11, 'h01, 0, 0, "ror");
        do_op(12, 'h10, 'h10, 0, "mul");
        do_op(13, 'h10, 'h10, 0, "mulh");
        do_op(15, 'h5A, 0, 0, "pass");
        do_op(1, 'hFF, 'h00, 1, "adc_wrap");
        do_op(3, 'h00, 'hFF, 1, "sbc_borrow");
        do_op(12, 'h00, 'hC3, 0, "mul_zero");
        do_op(12, 'hFF, 'hFF, 0, "mul_max");

        for (int i = 0; i < 40; i++)
            do_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 255)),
                  int'($urandom_range(0, 255)), int'($urandom_range(0, 1)), "rand");

        // start held high for the whole MUL, including the done cycle
        model(12, 'h0F, 'h11, 0, r, st);
        @(negedge clk);
        start = 1'b1; op = 4'd12; a = 8'h0F; b = 8'h11; carry_in = 1'b0;
        @(posedge clk);
        @(negedge clk);
        op = 4'd0; a = 8'h01; b = 8'h01;
        dones = 0;
        busy_low = 0;
        for (int i = 0; i < W + 2; i++) begin
            @(posedge clk);
            #1;
            if (!busy) busy_low++;
            if (done) begin
                dones++;
                exp_result = r;
                exp_status = st;
                check("spam.result", 32'(result), 32'(r));
                check("spam.status", 32'(alu_status), 32'(st));
            end
        end
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (done) dones++;
        end
        check("spam.dones", 32'(dones), 32'd1);
        check("spam.busy_cont", 32'(busy_low), 32'd0);
        check("spam.idle", 32'(busy), 32'd0);

        // reset three cycles into a multiply
        @(negedge clk);
        start = 1'b1; op = 4'd12; a = 8'hAB; b = 8'hCD;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        res_n = 1'b0;
        #1;
        check("abort.outs", {27'd0, busy, done, result_wr_en, stat_wr_en, |alu_status}, 32'd0);
        check("abort.result", 32'(result), 32'd0);
        exp_result = 0;
        exp_status = 0;
        repeat (2) @(negedge clk);
        res_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 14; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) dones++;
        end
        check("abort.no_done", 32'(dones), 32'd0);
        do_op(0, 1, 1, 0, "post_reset_add");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
